// File: rtl/dsp_fetch_pkg.sv
// Shared constants and state encoding for the DSP fetch stage.
// Imported by dsp_fetch and dsp_fetch_hold.
package dsp_fetch_pkg;

  localparam int MEM_ADDR_LEN = 16;
  localparam int INSTR_LEN    = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_RUN      = 2'd1,
    FETCH_REDIRECT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/dsp_fetch_hold.sv
// One-entry skid register for the fetch stage: parks a returning word
// while decode stalls and muxes it ahead of the live memory data.
module dsp_fetch_hold
  import dsp_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_LEN,
  parameter int INSTR_WIDTH = INSTR_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture,
  input  logic                   clear,
  input  logic                   live_valid,
  input  logic [INSTR_WIDTH-1:0] live_data,
  input  logic [ADDR_WIDTH-1:0]  live_pc,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  logic                   hv_q, hv_d;
  logic [INSTR_WIDTH-1:0] hd_q, hd_d;
  logic [ADDR_WIDTH-1:0]  hp_q, hp_d;

  always_comb begin
    hv_d = hv_q;
    hd_d = hd_q;
    hp_d = hp_q;
    if (clear) begin
      hv_d = 1'b0;
    end else if (capture) begin
      hv_d = 1'b1;
      hd_d = live_data;
      hp_d = live_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q <= 1'b0;
      hd_q <= '0;
      hp_q <= '0;
    end else begin
      hv_q <= hv_d;
      hd_q <= hd_d;
      hp_q <= hp_d;
    end
  end

  // Idle outputs read as zero rather than leaking stale memory data.
  always_comb begin
    out_valid = hv_q | live_valid;
    out_data  = '0;
    out_pc    = '0;
    if (hv_q) begin
      out_data = hd_q;
      out_pc   = hp_q;
    end else if (live_valid) begin
      out_data = live_data;
      out_pc   = live_pc;
    end
  end

endmodule

// File: rtl/dsp_fetch.sv
// DSP core fetch stage: owns the PC, issues one synchronous imem read
// per cycle and presents instr/pc pairs to decode under stall.
module dsp_fetch
  import dsp_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = MEM_ADDR_LEN,
  parameter int                    INSTR_WIDTH = INSTR_LEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jump_flag,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  input  logic                   stall,
  output logic                   imem_en,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  output logic                   flush
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pend_v_q, pend_v_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  flush_q, flush_d;

  logic issue;
  logic hold_cap;
  logic hold_clr;

  // A presented word that decode refuses blocks the next request.
  assign issue = (state_q != FETCH_IDLE) && !(stall && instr_valid);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_v_d  = 1'b0;
    pend_pc_d = pend_pc_q;
    flush_d   = 1'b0;
    hold_cap  = 1'b0;
    hold_clr  = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_RUN;
      end
      default: begin
        if (jump_flag == 1'b1) begin
          state_d  = FETCH_REDIRECT;
          pc_d     = jump_addr;
          flush_d  = 1'b1;
          hold_clr = 1'b1;
        end else begin
          state_d  = FETCH_RUN;
          hold_cap = stall && pend_v_q;
          hold_clr = !stall;
          if (issue) begin
            pc_d      = pc_q + PC_ONE;
            pend_v_d  = 1'b1;
            pend_pc_d = pc_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_ADDR;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      flush_q   <= flush_d;
    end
  end

  dsp_fetch_hold #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (hold_cap),
    .clear      (hold_clr),
    .live_valid (pend_v_q),
    .live_data  (imem_data),
    .live_pc    (pend_pc_q),
    .out_valid  (instr_valid),
    .out_data   (instr),
    .out_pc     (instr_pc)
  );

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_dsp_fetch.sv
// Directed bench for dsp_fetch: vector table plus reset and wrap
// sequences, against a synchronous memory returning addr ^ 16'h3C5A.
module tb_dsp_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag;
  logic [15:0] jump_addr;
  logic        stall;

  logic        en1, v1, fl1;
  logic [15:0] addr1, data1, instr1, ipc1;
  logic        en2, v2, fl2;
  logic [15:0] addr2, data2, instr2, ipc2;
  logic        tie0;
  logic [15:0] tie0w;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] e;

  always #5 clk = ~clk;

  assign tie0  = 1'b0;
  assign tie0w = 16'h0000;

  dsp_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .jump_flag(jump_flag), .jump_addr(jump_addr), .stall(stall),
    .imem_en(en1), .imem_addr(addr1), .imem_data(data1),
    .instr(instr1), .instr_pc(ipc1), .instr_valid(v1), .flush(fl1)
  );

  dsp_fetch #(.RESET_ADDR(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .jump_flag(tie0), .jump_addr(tie0w), .stall(tie0),
    .imem_en(en2), .imem_addr(addr2), .imem_data(data2),
    .instr(instr2), .instr_pc(ipc2), .instr_valid(v2), .flush(fl2)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h3C5A;
  endfunction

  // Output is garbage when not enabled so the hold path is exercised.
  always @(posedge clk) begin
    data1 <= en1 ? memf(addr1) : 16'hDEAD;
    data2 <= en2 ? memf(addr2) : 16'hDEAD;
  end

  typedef struct {
    logic        s;
    logic        j;
    logic [15:0] ja;
    logic        en;
    logic [15:0] addr;
    logic        v;
    logic [15:0] ipc;
    logic        fl;
  } vec_t;

  localparam int NV = 30;
  vec_t tv [NV];

  function automatic vec_t mk(input logic s, input logic j,
                              input logic [15:0] ja, input logic en,
                              input logic [15:0] addr, input logic v,
                              input logic [15:0] ipc, input logic fl);
    vec_t r;
    r.s = s; r.j = j; r.ja = ja; r.en = en;
    r.addr = addr; r.v = v; r.ipc = ipc; r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    tv[0]  = mk(0, 0,     16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
    tv[1]  = mk(0, 0,     16'h0000, 1, 16'h0001, 1, 16'h0000, 0);
    tv[2]  = mk(0, 0,     16'h0000, 1, 16'h0002, 1, 16'h0001, 0);
    tv[3]  = mk(0, 0,     16'h0000, 1, 16'h0003, 1, 16'h0002, 0);
    tv[4]  = mk(0, 0,     16'h0000, 1, 16'h0004, 1, 16'h0003, 0);
    tv[5]  = mk(0, 0,     16'h0000, 1, 16'h0005, 1, 16'h0004, 0);
    tv[6]  = mk(1, 0,     16'h0000, 0, 16'h0006, 1, 16'h0005, 0);
    tv[7]  = mk(1, 0,     16'h0000, 0, 16'h0006, 1, 16'h0005, 0);
    tv[8]  = mk(1, 0,     16'h0000, 0, 16'h0006, 1, 16'h0005, 0);
    tv[9]  = mk(0, 0,     16'h0000, 1, 16'h0006, 1, 16'h0005, 0);
    tv[10] = mk(0, 0,     16'h0000, 1, 16'h0007, 1, 16'h0006, 0);
    tv[11] = mk(0, 0,     16'h0000, 1, 16'h0008, 1, 16'h0007, 0);
    tv[12] = mk(0, 1,     16'h0040, 1, 16'h0009, 1, 16'h0008, 0);
    tv[13] = mk(0, 0,     16'h0000, 1, 16'h0040, 0, 16'h0000, 1);
    tv[14] = mk(0, 0,     16'h0000, 1, 16'h0041, 1, 16'h0040, 0);
    tv[15] = mk(0, 0,     16'h0000, 1, 16'h0042, 1, 16'h0041, 0);
    tv[16] = mk(0, 1,     16'h0080, 1, 16'h0043, 1, 16'h0042, 0);
    tv[17] = mk(0, 1,     16'h0090, 1, 16'h0080, 0, 16'h0000, 1);
    tv[18] = mk(0, 0,     16'h0000, 1, 16'h0090, 0, 16'h0000, 1);
    tv[19] = mk(0, 0,     16'h0000, 1, 16'h0091, 1, 16'h0090, 0);
    tv[20] = mk(0, 1,     16'h00A0, 1, 16'h0092, 1, 16'h0091, 0);
    tv[21] = mk(1, 0,     16'h0000, 1, 16'h00A0, 0, 16'h0000, 1);
    tv[22] = mk(1, 0,     16'h0000, 0, 16'h00A1, 1, 16'h00A0, 0);
    tv[23] = mk(0, 0,     16'h0000, 1, 16'h00A1, 1, 16'h00A0, 0);
    tv[24] = mk(1, 0,     16'h0000, 0, 16'h00A2, 1, 16'h00A1, 0);
    tv[25] = mk(1, 1,     16'h0100, 0, 16'h00A2, 1, 16'h00A1, 0);
    tv[26] = mk(1, 0,     16'h0000, 1, 16'h0100, 0, 16'h0000, 1);
    tv[27] = mk(0, 0,     16'h0000, 1, 16'h0101, 1, 16'h0100, 0);
    tv[28] = mk(0, 1'bx,  16'h0200, 1, 16'h0102, 1, 16'h0101, 0);
    tv[29] = mk(0, 0,     16'h0000, 1, 16'h0103, 1, 16'h0102, 0);

    rst_n = 1'b0;
    stall = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_en", 0, {31'd0, en1}, 32'd0);
    chk("rst_instr", 0, {16'd0, instr1}, 32'd0);
    chk("rst_pc", 0, {16'd0, ipc1}, 32'd0);
    chk("rst_valid", 0, {31'd0, v1}, 32'd0);
    chk("rst_flush", 0, {31'd0, fl1}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      stall     = tv[i].s;
      jump_flag = tv[i].j;
      jump_addr = tv[i].ja;
      @(negedge clk);
      chk("imem_en", i, {31'd0, en1}, {31'd0, tv[i].en});
      chk("imem_addr", i, {16'd0, addr1}, {16'd0, tv[i].addr});
      chk("valid", i, {31'd0, v1}, {31'd0, tv[i].v});
      chk("flush", i, {31'd0, fl1}, {31'd0, tv[i].fl});
      if (tv[i].v) begin
        chk("instr_pc", i, {16'd0, ipc1}, {16'd0, tv[i].ipc});
        chk("instr", i, {16'd0, instr1}, {16'd0, memf(tv[i].ipc)});
      end
      if (i >= 1 && i <= 4) begin
        e = 16'hFFFE + 16'(i - 1);
        chk("wrap_valid", i, {31'd0, v2}, 32'd1);
        chk("wrap_pc", i, {16'd0, ipc2}, {16'd0, e});
        chk("wrap_instr", i, {16'd0, instr2}, {16'd0, memf(e)});
      end
    end

    // Fill the hold register, then pull reset underneath it.
    @(posedge clk);
    #1;
    stall = 1'b1;
    jump_flag = 1'b0;
    @(negedge clk);
    chk("hs_en", 100, {31'd0, en1}, 32'd0);
    chk("hs_pc", 100, {16'd0, ipc1}, 32'h0103);
    @(posedge clk);
    @(negedge clk);
    chk("hs_hold_instr", 101, {16'd0, instr1}, {16'd0, memf(16'h0103)});
    chk("hs_hold_pc", 101, {16'd0, ipc1}, 32'h0103);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_en", 102, {31'd0, en1}, 32'd0);
    chk("ar_valid", 102, {31'd0, v1}, 32'd0);
    chk("ar_instr", 102, {16'd0, instr1}, 32'd0);
    chk("ar_pc", 102, {16'd0, ipc1}, 32'd0);
    chk("ar_flush", 102, {31'd0, fl1}, 32'd0);
    chk("ar_addr", 102, {16'd0, addr1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rs_en", 103, {31'd0, en1}, 32'd1);
    chk("rs_addr", 103, {16'd0, addr1}, 32'd0);
    chk("rs_valid", 103, {31'd0, v1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rs_valid2", 104, {31'd0, v1}, 32'd1);
    chk("rs_pc", 104, {16'd0, ipc1}, 32'd0);
    chk("rs_instr", 104, {16'd0, instr1}, {16'd0, memf(16'h0000)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
